// File: rtl/draw_pixel_sink.sv
// draw_pixel_sink: offsets, clips and colour-keys image pixels into single-cycle VGA plot strobes with per-image counts
module draw_pixel_sink #(
    parameter logic [8:0] TRANSPARENT = 9'h1C7,
    parameter bit TRANSPARENT_EN = 1'b1,
    parameter int X_MAX = 320,
    parameter int Y_MAX = 240
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ld_base,
    input  logic [8:0]  base_x,
    input  logic [8:0]  base_y,
    input  logic        ld_pos,
    input  logic        ld_colour,
    input  logic        draw_pixel,
    input  logic        done_in,
    input  logic [8:0]  dx,
    input  logic [8:0]  dy,
    input  logic [8:0]  colour_in,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [8:0]  vga_colour,
    output logic        vga_plot,
    output logic [16:0] plotted_count,
    output logic [16:0] skipped_count,
    output logic        image_done
);
    localparam logic [9:0] XM = 10'(X_MAX);
    localparam logic [9:0] YM = 10'(Y_MAX);
    localparam logic [16:0] CNT_MAX = '1;
    logic [8:0] x_base, y_base, col_reg;
    logic [9:0] x_pos, y_pos;
    logic visible;
    always_comb visible = (x_pos < XM) && (y_pos < YM) && !(TRANSPARENT_EN && col_reg == TRANSPARENT);
    always_ff @(posedge clock) begin
        if (reset) begin
            x_base <= '0;
            y_base <= '0;
            x_pos <= '0;
            y_pos <= '0;
            col_reg <= '0;
            vga_x <= '0;
            vga_y <= '0;
            vga_colour <= '0;
            vga_plot <= 1'b0;
            plotted_count <= '0;
            skipped_count <= '0;
            image_done <= 1'b0;
        end else begin
            if (ld_base) begin
                x_base <= base_x;
                y_base <= base_y;
            end
            // 10-bit sums so off-screen positions never alias back on screen
            if (ld_pos) begin
                x_pos <= {1'b0, x_base} + {1'b0, dx};
                y_pos <= {1'b0, y_base} + {1'b0, dy};
            end
            if (ld_colour)
                col_reg <= colour_in;
            vga_plot <= draw_pixel && visible;
            image_done <= done_in;
            if (draw_pixel && visible) begin
                vga_x <= x_pos[8:0];
                vga_y <= y_pos[7:0];
                vga_colour <= col_reg;
            end
            if (ld_base) begin
                plotted_count <= '0;
                skipped_count <= '0;
            end else if (draw_pixel) begin
                if (visible)
                    plotted_count <= plotted_count + {16'b0, plotted_count != CNT_MAX};
                else
                    skipped_count <= skipped_count + {16'b0, skipped_count != CNT_MAX};
            end
        end
    end
endmodule

// File: tb/tb_draw_pixel_sink.sv
// tb_draw_pixel_sink: random and directed stimulus against a behavioural pixel-sink model, keyed and unkeyed instances
module tb_draw_pixel_sink;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ld_base = 0, ld_pos = 0, ld_colour = 0, draw_pixel = 0, done_in = 0;
    logic [8:0] base_x = 0, base_y = 0, dx = 0, dy = 0, colour_in = 0;
    logic [8:0] vx[2];
    logic [7:0] vy[2];
    logic [8:0] vc[2];
    logic vp[2];
    logic [16:0] pc_o[2], sc_o[2];
    logic idone[2];
    int compared = 0, mismatched = 0;
    bit chk_on = 0;
    int pulses = 0;
    int bx = 0, by = 0, px = 0, py = 0, pcol = 0;
    int e_plot[2], e_x[2], e_y[2], e_c[2], e_pl[2], e_sk[2];
    int e_done = 0;

    always #5 clock = ~clock;

    draw_pixel_sink #(.TRANSPARENT_EN(1'b1)) dut0 (
        .clock(clock), .reset(reset), .ld_base(ld_base), .base_x(base_x), .base_y(base_y),
        .ld_pos(ld_pos), .ld_colour(ld_colour), .draw_pixel(draw_pixel), .done_in(done_in),
        .dx(dx), .dy(dy), .colour_in(colour_in), .vga_x(vx[0]), .vga_y(vy[0]), .vga_colour(vc[0]),
        .vga_plot(vp[0]), .plotted_count(pc_o[0]), .skipped_count(sc_o[0]), .image_done(idone[0]));
    draw_pixel_sink #(.TRANSPARENT_EN(1'b0)) dut1 (
        .clock(clock), .reset(reset), .ld_base(ld_base), .base_x(base_x), .base_y(base_y),
        .ld_pos(ld_pos), .ld_colour(ld_colour), .draw_pixel(draw_pixel), .done_in(done_in),
        .dx(dx), .dy(dy), .colour_in(colour_in), .vga_x(vx[1]), .vga_y(vy[1]), .vga_colour(vc[1]),
        .vga_plot(vp[1]), .plotted_count(pc_o[1]), .skipped_count(sc_o[1]), .image_done(idone[1]));

    function automatic void chk(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    // Spec-level model: pixel position is base plus offset, plotted if on-frame and not keyed
    always @(posedge clock) begin
        bit v[2];
        for (int k = 0; k < 2; k++)
            v[k] = px < 320 && py < 240 && !(k == 0 && pcol == 'h1C7);
        if (reset) begin
            bx = 0; by = 0; px = 0; py = 0; pcol = 0; e_done = 0;
            for (int k = 0; k < 2; k++) begin
                e_plot[k] = 0; e_x[k] = 0; e_y[k] = 0; e_c[k] = 0; e_pl[k] = 0; e_sk[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                e_plot[k] = (draw_pixel && v[k]) ? 1 : 0;
                if (e_plot[k] == 1) begin
                    e_x[k] = px; e_y[k] = py % 256; e_c[k] = pcol;
                end
                if (ld_base) begin
                    e_pl[k] = 0; e_sk[k] = 0;
                end else if (draw_pixel) begin
                    if (v[k]) e_pl[k] = (e_pl[k] < 131071) ? e_pl[k] + 1 : e_pl[k];
                    else e_sk[k] = (e_sk[k] < 131071) ? e_sk[k] + 1 : e_sk[k];
                end
            end
            e_done = done_in ? 1 : 0;
            if (ld_pos) begin
                px = bx + int'(dx); py = by + int'(dy);
            end
            if (ld_colour) pcol = int'(colour_in);
            if (ld_base) begin
                bx = int'(base_x); by = int'(base_y);
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                chk("model_plot", int'(vp[k]), e_plot[k]);
                chk("model_x", int'(vx[k]), e_x[k]);
                chk("model_y", int'(vy[k]), e_y[k]);
                chk("model_colour", int'(vc[k]), e_c[k]);
                chk("model_plotted", int'(pc_o[k]), e_pl[k]);
                chk("model_skipped", int'(sc_o[k]), e_sk[k]);
                chk("model_done", int'(idone[k]), e_done);
            end
            if (vp[0]) pulses++;
        end
    end

    task automatic stb(input bit lb, input bit lp, input bit lc, input bit dr, input bit dn);
        ld_base = lb; ld_pos = lp; ld_colour = lc; draw_pixel = dr; done_in = dn;
        @(negedge clock);
        ld_base = 0; ld_pos = 0; ld_colour = 0; draw_pixel = 0; done_in = 0;
    endtask

    task automatic pix(input int x, input int y, input int c);
        dx = 9'(x); dy = 9'(y); colour_in = 9'(c);
        stb(0, 1, 1, 0, 0);
        stb(0, 0, 0, 1, 0);
    endtask

    initial begin
        int p0;
        int col;
        bit ok;
        // reset with strobes active
        ld_base = 1; ld_pos = 1; ld_colour = 1; draw_pixel = 1; done_in = 1;
        base_x = 9'd5; base_y = 9'd5; dx = 9'd1; dy = 9'd1; colour_in = 9'h0A5;
        repeat (2) @(negedge clock);
        chk_on = 1;
        chk("rst_plot", int'(vp[0]), 0);
        chk("rst_done", int'(idone[0]), 0);
        chk("rst_plotted", int'(pc_o[0]), 0);
        ld_base = 0; ld_pos = 0; ld_colour = 0; draw_pixel = 0; done_in = 0;
        reset = 0;
        repeat (2) @(negedge clock);
        chk("post_rst_plotted", int'(pc_o[0]), 0);
        chk("post_rst_skipped", int'(sc_o[0]), 0);

        // basic plot
        base_x = 9'd10; base_y = 9'd20;
        stb(1, 0, 0, 0, 0);
        pix(3, 4, 'h0A5);
        chk("basic_plot", int'(vp[0]), 1);
        chk("basic_x", int'(vx[0]), 13);
        chk("basic_y", int'(vy[0]), 24);
        chk("basic_colour", int'(vc[0]), 'h0A5);
        chk("basic_plotted", int'(pc_o[0]), 1);
        stb(0, 0, 0, 0, 0);
        chk("basic_one_cycle", int'(vp[0]), 0);
        chk("basic_hold_x", int'(vx[0]), 13);

        // reset mid-image with a draw pending
        reset = 1;
        stb(0, 0, 0, 1, 0);
        reset = 0;
        chk("rst_draw_plot", int'(vp[0]), 0);
        chk("rst_draw_plotted", int'(pc_o[0]), 0);

        // clipping
        base_x = 9'd300; base_y = 9'd230;
        stb(1, 0, 0, 0, 0);
        pix(25, 0, 'h0A5);
        chk("clip_x325_plot", int'(vp[0]), 0);
        chk("clip_x325_skipped", int'(sc_o[0]), 1);
        pix(19, 9, 'h0A5);
        chk("clip_corner_plot", int'(vp[0]), 1);
        chk("clip_corner_x", int'(vx[0]), 319);
        chk("clip_corner_y", int'(vy[0]), 239);
        pix(20, 9, 'h0A5);
        chk("clip_x320_plot", int'(vp[0]), 0);
        chk("clip_x320_skipped", int'(sc_o[0]), 2);

        // transparency: keyed instance drops, unkeyed instance plots
        base_x = 9'd10; base_y = 9'd20;
        stb(1, 0, 0, 0, 0);
        pix(1, 1, 'h1C7);
        chk("key_en_plot", int'(vp[0]), 0);
        chk("key_en_skipped", int'(sc_o[0]), 1);
        chk("key_dis_plot", int'(vp[1]), 1);
        chk("key_dis_x", int'(vx[1]), 11);
        chk("key_dis_y", int'(vy[1]), 21);
        chk("key_dis_colour", int'(vc[1]), 'h1C7);

        // same-cycle conflicts
        pix(2, 2, 'h011);
        dx = 9'd7; dy = 9'd7;
        stb(0, 1, 0, 1, 0);
        chk("pos_draw_x", int'(vx[0]), 12);
        chk("pos_draw_y", int'(vy[0]), 22);
        base_x = 9'd100; base_y = 9'd100; dx = 9'd1; dy = 9'd1;
        stb(1, 1, 0, 0, 0);
        stb(0, 0, 0, 1, 0);
        chk("base_pos_x", int'(vx[0]), 11);
        chk("base_pos_y", int'(vy[0]), 21);
        stb(1, 0, 0, 1, 0);
        chk("base_draw_plot", int'(vp[0]), 1);
        chk("base_draw_plotted", int'(pc_o[0]), 0);
        chk("base_draw_skipped", int'(sc_o[0]), 0);

        // full 44x59 card at (0,0)
        base_x = 0; base_y = 0;
        stb(1, 0, 0, 0, 0);
        p0 = pulses;
        ok = 1;
        for (int y = 0; y < 59; y++)
            for (int x = 0; x < 44; x++) begin
                col = int'($urandom_range(0, 511));
                if (col == 'h1C7) col = 0;
                pix(x, y, col);
                if (!(vp[0] && int'(vx[0]) == x && int'(vy[0]) == y && int'(vc[0]) == col)) ok = 0;
                stb(0, 0, 0, 0, 0);
                stb(0, 0, 0, 0, 0);
            end
        chk("card_raster_ok", int'(ok), 1);
        chk("card_pulses", pulses - p0, 2596);
        stb(0, 0, 0, 0, 1);
        chk("card_done", int'(idone[0]), 1);
        chk("card_plotted", int'(pc_o[0]), 2596);
        chk("card_skipped", int'(sc_o[0]), 0);
        stb(0, 0, 0, 0, 0);
        chk("card_done_pulse", int'(idone[0]), 0);
        stb(1, 0, 0, 0, 0);
        chk("card_clear_plotted", int'(pc_o[0]), 0);

        // held done_in gives one pulse per cycle
        done_in = 1;
        repeat (3) @(negedge clock);
        chk("done_held", int'(idone[0]), 1);
        done_in = 0;

        // randomized traffic against the model
        repeat (3000) begin
            reset = ($urandom_range(0, 60) == 0);
            base_x = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 330));
            base_y = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 250));
            dx = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 40));
            dy = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'($urandom_range(0, 40));
            colour_in = ($urandom_range(0, 3) == 0) ? 9'h1C7 : 9'($urandom);
            ld_base = ($urandom_range(0, 15) == 0);
            ld_pos = ($urandom_range(0, 2) == 0);
            ld_colour = ($urandom_range(0, 2) == 0);
            draw_pixel = ($urandom_range(0, 1) == 0);
            done_in = ($urandom_range(0, 9) == 0);
            @(negedge clock);
        end
        reset = 0;
        stb(0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/draw_pixel_sink.md
# draw_pixel_sink

Receiving end of the image-plotting handshake. It consumes the `ld_pos` / `ld_colour` / `draw_pixel` / `done` strobes and the `dx` / `dy` / `colour` stream produced by the image-drawing FSM. It offsets each pixel by a latched on-screen base position, then clips it to the 320x240 frame and drops transparent-key pixels. Surviving pixels go to the VGA adapter write port as single-cycle plot pulses, and the block reports per-image plotted/skipped counts plus an image-complete pulse to the scene controller.

## Interface
Parameters:
- `TRANSPARENT`, 9'h1C7, colour key (RGB 3-3-3: R=7, G=0, B=7) treated as transparent.
- `TRANSPARENT_EN`, 1, 1 = key pixels are dropped; 0 = key pixels are plotted like any other colour.
- `X_MAX`, 320, frame width; on-screen x must satisfy x < X_MAX.
- `Y_MAX`, 240, frame height; on-screen y must satisfy y < Y_MAX.

Ports:
- `clock`  in  1  system clock. One clock; all logic is on its rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `ld_base`  in  1  latch `base_x` / `base_y`; also clears both counters.
- `base_x`  in  9  image top-left x.
- `base_y`  in  9  image top-left y.
- `ld_pos`  in  1  latch pixel position: base + offset.
- `ld_colour`  in  1  latch `colour_in`.
- `draw_pixel`  in  1  plot the latched pixel.
- `done_in`  in  1  image FSM finished.
- `dx`  in  9  pixel x offset.
- `dy`  in  9  pixel y offset.
- `colour_in`  in  9  pixel colour.
- `vga_x`  out  9  VGA write x.
- `vga_y`  out  8  VGA write y.
- `vga_colour`  out  9  VGA write colour.
- `vga_plot`  out  1  VGA write enable, one cycle per plotted pixel.
- `plotted_count`  out  17  pixels plotted since the last `ld_base`.
- `skipped_count`  out  17  pixels clipped or keyed since the last `ld_base`.
- `image_done`  out  1  one-cycle pulse the cycle after `done_in`.

## Operation
- **Registers:** `x_base`, `y_base` (9b); `x_pos`, `y_pos` (10b, hold the full sum); `col_reg` (9b); both counters; all outputs.
- **`ld_base`:**
  - `x_base` <= `base_x`, `y_base` <= `base_y`.
  - `plotted_count` <= 0, `skipped_count` <= 0.
- **`ld_pos`:** `x_pos` <= {1'b0, `x_base`} + `dx`; `y_pos` <= {1'b0, `y_base`} + `dy`.
  - The 10-bit sum never wraps, so an off-screen result is never aliased back onto the screen.
  - The sum uses the register values before this edge. If `ld_base` is asserted in the same cycle, `ld_pos` uses the old base.
- **`ld_colour`:** `col_reg` <= `colour_in`. It may coincide with `ld_pos`.
- **`draw_pixel`:** evaluate `visible` from the register values before this edge.
  - `visible` = (`x_pos` < X_MAX) && (`y_pos` < Y_MAX) && !(TRANSPARENT_EN && `col_reg` == TRANSPARENT).
  - If visible: next edge sets `vga_plot` = 1, `vga_x` = `x_pos[8:0]`, `vga_y` = `y_pos[7:0]`, `vga_colour` = `col_reg`, and increments `plotted_count`.
  - Otherwise: `vga_plot` = 0 and `skipped_count` increments.
- **Counter saturation:** both counters saturate at 17'h1FFFF; they never wrap.
- **Output hold:** `vga_x` / `vga_y` / `vga_colour` hold their last plotted values when `vga_plot` = 0.
- **Same-cycle conflicts:**
  - `draw_pixel` in the same cycle as `ld_pos` or `ld_colour` plots the previously latched pixel.
  - `draw_pixel` in the same cycle as `ld_base` clears the counters; the clear wins and the pixel is not counted. The VGA write still occurs if visible.
- **`done_in`:** `image_done` = 1 for exactly one cycle, on the edge after `done_in`. Holding `done_in` for N cycles produces N pulses; no edge detection is performed.

## Timing
- **Reset values:** on `reset`, every register and output is 0 on the next edge, including `vga_plot`, the VGA bus, both counters and `image_done`. This applies mid-image: a `draw_pixel` in the reset cycle produces no plot.
- **Latency:**
  - `ld_pos` / `ld_colour` at cycle t: values usable by a `draw_pixel` at t+1 or later.
  - `draw_pixel` at cycle t: `vga_plot` and the counter update are visible after edge t+1. The adapter samples the VGA bus in the cycle `vga_plot` is high.
- **Throughput:** one `draw_pixel` per cycle is supported. Back-to-back `draw_pixel` strobes with no new `ld_pos` plot the same pixel again and count it again.
- **Counts at `image_done`:** the image FSM asserts `done_in` at least 2 cycles after its last `draw_pixel`, so the counts are final while `image_done` is high.

## Test plan
- **Reset:** reset held 2 cycles while strobes are active -> all outputs 0; after release, counters remain 0 until the first plot.
- **Basic plot:**
  - Stimulus: `ld_base` (10,20); `ld_pos` dx=3, dy=4 with `ld_colour` 9'h0A5; next cycle `draw_pixel`.
  - Required: `vga_plot` high for exactly 1 cycle with x=13, y=24, colour 9'h0A5; `plotted_count` = 1.
- **Clipping:**
  - Base (300,230). dx=25, dy=0 -> x=325: no plot, `skipped_count` = 1.
  - dx=19, dy=9 -> (319,239): plotted.
  - dx=20 -> x=320: skipped.
- **Transparency:**
  - Colour 9'h1C7 with TRANSPARENT_EN=1 -> no plot, skipped +1.
  - Same stimulus with TRANSPARENT_EN=0 -> plotted at the computed position.
- **Full card:** 44x59 image at base (0,0), driven with the image FSM strobe sequence (about 4 cycles/pixel), no key colours.
  - Required: 2596 `vga_plot` pulses, covering x 0-43 and y 0-58 in raster order.
  - `image_done` one cycle after `done_in`, with `plotted_count` = 2596 and `skipped_count` = 0.
  - A subsequent `ld_base` clears both counters.
- **Same-cycle conflicts:**
  - `ld_pos` + `draw_pixel` in one cycle -> plots the old position.
  - `ld_base` + `ld_pos` in one cycle -> the sum uses the old base.
  - `ld_base` + `draw_pixel` in one cycle -> counters read 0 afterwards.
